// File: rtl/adc_ref_formatter_pkg.sv
// Shared definitions for the ADC/setpoint formatter: FSM encoding, width
// derivations and the default alignment constants used by the loop blocks.
package adc_ref_formatter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_e;

  localparam int DEF_FRAC   = 2;
  localparam int DEF_OFFSET = 128;

  function automatic int sel_w(input int msb, input int lsb);
    return msb - lsb + 1;
  endfunction

  function automatic int acc_w(input int field_w, input int avg_log2);
    return field_w + avg_log2;
  endfunction

  // The sample counter keeps at least one bit even when averaging is disabled.
  function automatic int cnt_w(input int avg_log2);
    return (avg_log2 > 0) ? avg_log2 : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_ref_formatter_fixpt_align.sv
// Combinational fixed-point alignment: zero-extend an unsigned field, append
// FRAC fractional zeros and remove a constant offset, giving a signed result.
module adc_ref_formatter_fixpt_align #(
  parameter int IN_W   = 8,
  parameter int FRAC   = 2,
  parameter int OUT_W  = 19,
  parameter int OFFSET = 128
) (
  input  logic [IN_W-1:0]         x_i,
  output logic signed [OUT_W-1:0] y_o
);

  localparam logic signed [OUT_W-1:0] OFFSET_S = OUT_W'(OFFSET);

  // Headroom is guaranteed by the caller's width check, so no saturation.
  function automatic logic signed [OUT_W-1:0] align(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] shifted;
    shifted = OUT_W'(x) << FRAC;
    return $signed(shifted) - OFFSET_S;
  endfunction

  assign y_o = align(x_i);

endmodule

// File: rtl/adc_ref_formatter.sv
// Registered setpoint/ADC formatter with optional block averaging of
// 2^AVG_LOG2 conversions and a one-cycle strobe per formatted sample.
module adc_ref_formatter
  import adc_ref_formatter_pkg::*;
#(
  parameter int REF_W    = 8,
  parameter int ADC_W    = 16,
  parameter int SEL_MSB  = 11,
  parameter int SEL_LSB  = 4,
  parameter int FRAC     = DEF_FRAC,
  parameter int OUT_W    = 19,
  parameter int OFFSET   = DEF_OFFSET,
  parameter int AVG_LOG2 = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REF_W-1:0]              ref_i,
  input  logic [ADC_W-1:0]              datoADC,
  input  logic                          adc_valid,
  input  logic                          avg_en,
  output logic signed [OUT_W-1:0]       dato_ref,
  output logic signed [OUT_W-1:0]       dato_adc,
  output logic                          out_valid,
  output logic [cnt_w(AVG_LOG2)-1:0]    sample_cnt
);

  localparam int SEL_W  = sel_w(SEL_MSB, SEL_LSB);
  localparam int ACC_W  = acc_w(SEL_W, AVG_LOG2);
  localparam int CNT_W  = cnt_w(AVG_LOG2);
  localparam bit AVG_OK = (AVG_LOG2 > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  if (OUT_W < max2(REF_W, SEL_W) + FRAC + 1) begin : g_out_w_check
    $error("adc_ref_formatter: OUT_W too small for REF_W/SEL_W/FRAC");
  end
  if (AVG_LOG2 < 0 || AVG_LOG2 > 6) begin : g_avg_check
    $error("adc_ref_formatter: AVG_LOG2 must be within 0..6");
  end

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] dref_q, dref_d;
  logic signed [OUT_W-1:0] dadc_q, dadc_d;

  logic [SEL_W-1:0]        field;
  logic [ACC_W-1:0]        sum;
  logic [SEL_W-1:0]        mean;
  logic [SEL_W-1:0]        adc_sel;
  logic                    block_start;
  logic                    pass;
  logic signed [OUT_W-1:0] ref_fmt;
  logic signed [OUT_W-1:0] adc_fmt;
  logic                    unused_adc_bits;

  // Bits of the raw word outside the selected field are deliberately ignored.
  assign unused_adc_bits = ^datoADC;

  assign field       = datoADC[SEL_MSB:SEL_LSB];
  assign sum         = acc_q + ACC_W'(field);
  assign mean        = SEL_W'(sum >> AVG_LOG2);
  assign block_start = adc_valid && (state_q != ACCUM);
  // Mode comes from avg_en only when a new block starts; mid-block it is frozen.
  assign pass        = !AVG_OK || !(block_start ? avg_en : mode_q);
  assign adc_sel     = pass ? field : mean;

  adc_ref_formatter_fixpt_align #(
    .IN_W(REF_W), .FRAC(FRAC), .OUT_W(OUT_W), .OFFSET(OFFSET)
  ) u_align_ref (
    .x_i(ref_i),
    .y_o(ref_fmt)
  );

  adc_ref_formatter_fixpt_align #(
    .IN_W(SEL_W), .FRAC(FRAC), .OUT_W(OUT_W), .OFFSET(OFFSET)
  ) u_align_adc (
    .x_i(adc_sel),
    .y_o(adc_fmt)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dref_d  = dref_q;
    dadc_d  = dadc_q;
    if (adc_valid) begin
      if (block_start) mode_d = avg_en;
      if (pass || cnt_q == CNT_LAST) begin
        // Block complete: setpoint is captured on the same edge as the data.
        dref_d  = ref_fmt;
        dadc_d  = adc_fmt;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = EMIT;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_q + 1'b1;
        state_d = ACCUM;
      end
    end else if (state_q == EMIT) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dref_q  <= '0;
      dadc_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dref_q  <= dref_d;
      dadc_q  <= dadc_d;
    end
  end

  assign dato_ref   = dref_q;
  assign dato_adc   = dadc_q;
  assign out_valid  = (state_q == EMIT);
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_adc_ref_formatter.sv
// Directed bench for adc_ref_formatter with default parameters
// (8-bit setpoint, field datoADC[11:4], FRAC=2, OFFSET=128, 4-sample average).
module tb_adc_ref_formatter;

  logic               clk;
  logic               rst_n;
  logic [7:0]         ref_i;
  logic [15:0]        datoADC;
  logic               adc_valid;
  logic               avg_en;
  logic signed [18:0] dato_ref;
  logic signed [18:0] dato_adc;
  logic               out_valid;
  logic [1:0]         sample_cnt;

  int n_checks;
  int n_errors;

  adc_ref_formatter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ref_i     (ref_i),
    .datoADC   (datoADC),
    .adc_valid (adc_valid),
    .avg_en    (avg_en),
    .dato_ref  (dato_ref),
    .dato_adc  (dato_adc),
    .out_valid (out_valid),
    .sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Places an 8-bit field at datoADC[11:4] with adc_valid high for one edge.
  task automatic sample(input logic [7:0] f);
    datoADC   = {4'h0, f, 4'h0};
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] bb [8];
    int strobes;
    int first_strobe;
    int last_strobe;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    ref_i     = '0;
    datoADC   = '0;
    adc_valid = 1'b0;
    avg_en    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_dato_ref", dato_ref, 0);
    chk("rst_dato_adc", dato_adc, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sample_cnt", sample_cnt, 0);

    // Pass-through
    ref_i = 8'h80; datoADC = 16'h0A50; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    chk("pt_dato_ref", dato_ref, 384);
    chk("pt_dato_adc", dato_adc, 532);
    chk("pt_out_valid", out_valid, 1);
    ref_i = 8'h33;
    tick();
    chk("pt_strobe_drop", out_valid, 0);
    chk("pt_hold_adc", dato_adc, 532);
    chk("pt_ref_not_continuous", dato_ref, 384);

    // Boundaries
    ref_i = 8'h00; datoADC = 16'h0000; adc_valid = 1'b1;
    tick();
    chk("bnd_ref_min", dato_ref, -128);
    chk("bnd_adc_min", dato_adc, -128);
    ref_i = 8'hFF; datoADC = 16'hFFFF;
    tick();
    chk("bnd_ref_max", dato_ref, 892);
    chk("bnd_adc_max", dato_adc, 892);
    chk("bnd_b2b_valid", out_valid, 1);
    datoADC = 16'hF00F;
    tick();
    adc_valid = 1'b0;
    chk("bnd_outside_bits", dato_adc, -128);
    tick();

    // Averaging on non-consecutive cycles
    avg_en = 1'b1; ref_i = 8'h10;
    sample(8'h10);
    chk("avg_cnt1", sample_cnt, 1);
    chk("avg_no_strobe1", out_valid, 0);
    chk("avg_ref_hold", dato_ref, 892);
    tick();
    chk("avg_hold_cnt", sample_cnt, 1);
    sample(8'h20);
    chk("avg_cnt2", sample_cnt, 2);
    tick();
    sample(8'h30);
    chk("avg_cnt3", sample_cnt, 3);
    chk("avg_no_strobe3", out_valid, 0);
    tick();
    sample(8'h41);
    chk("avg_mean", dato_adc, 32);
    chk("avg_ref", dato_ref, -64);
    chk("avg_strobe", out_valid, 1);
    chk("avg_cnt_clear", sample_cnt, 0);
    tick();
    chk("avg_strobe_once", out_valid, 0);

    // Back-to-back averaging, 8 samples
    bb = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd100, 8'd100, 8'd100, 8'd103};
    strobes = 0; first_strobe = -1; last_strobe = -1;
    adc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      datoADC = {4'h0, bb[i], 4'h0};
      tick();
      chk("b2b_valid", out_valid, (i == 3 || i == 7) ? 1 : 0);
      if (out_valid) begin
        strobes++;
        if (first_strobe < 0) first_strobe = i;
        last_strobe = i;
      end
      if (i == 3) chk("b2b_mean1", dato_adc, -88);
      if (i == 7) chk("b2b_mean2", dato_adc, 272);
    end
    adc_valid = 1'b0;
    chk("b2b_strobes", strobes, 2);
    chk("b2b_spacing", last_strobe - first_strobe, 4);
    tick();

    // avg_en dropped mid-block: block still averages, next sample passes through
    avg_en = 1'b1;
    adc_valid = 1'b1;
    datoADC = {4'h0, 8'h20, 4'h0};
    tick();
    tick();
    avg_en = 1'b0;
    tick();
    chk("tog_cnt3", sample_cnt, 3);
    chk("tog_no_strobe", out_valid, 0);
    datoADC = {4'h0, 8'h24, 4'h0};
    tick();
    chk("tog_mean", dato_adc, 4);
    chk("tog_strobe", out_valid, 1);
    datoADC = {4'h0, 8'h50, 4'h0};
    tick();
    adc_valid = 1'b0;
    chk("tog_pass", dato_adc, 192);
    chk("tog_pass_valid", out_valid, 1);
    chk("tog_pass_cnt", sample_cnt, 0);
    tick();

    // Reset mid-block discards the partial accumulation
    avg_en = 1'b1;
    sample(8'hFF);
    sample(8'hFF);
    sample(8'hFF);
    tick();
    chk("mid_cnt3", sample_cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_adc", dato_adc, 0);
    chk("mid_rst_ref", dato_ref, 0);
    chk("mid_rst_cnt", sample_cnt, 0);
    chk("mid_rst_valid", out_valid, 0);
    tick();
    chk("mid_rst_no_strobe", out_valid, 0);
    rst_n = 1'b1;
    tick();
    sample(8'h40);
    sample(8'h40);
    sample(8'h40);
    chk("mid_new_cnt3", sample_cnt, 3);
    chk("mid_no_early_strobe", out_valid, 0);
    sample(8'h40);
    chk("mid_new_mean", dato_adc, 128);
    chk("mid_new_strobe", out_valid, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
